// File: rtl/dac_spi_arb_pkg.sv
// Shared types and constants for the DAC SPI arbiter.
package dac_spi_arb_pkg;

  // Transfer sequencer states
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    GAP
  } state_t;

  // Requester port indices
  localparam int PORT_CPU = 0;
  localparam int PORT_HW  = 1;

endpackage

// File: rtl/spi_rr_arb2.sv
// Two-port round-robin arbiter: a lone request wins outright, and on a tie
// the port that was not granted last time wins. The grant is one-hot and combinational.
module spi_rr_arb2
  import dac_spi_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last_grant,
  output logic [1:0] grant
);

  logic [1:0] req;

  assign req[PORT_CPU] = req0;
  assign req[PORT_HW]  = req1;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign grant[gi] = req[gi] & (~req[1-gi] | (last_grant != 1'(gi)));
    end
  endgenerate

endmodule

// File: rtl/dac_spi_arb.sv
// Shares one mode-0 DAC SPI link between a CPU requester and a HW tuning
// requester. Each transfer is a fixed-length exchange, MSB first. The received word
// is returned to the port that won arbitration.
module dac_spi_arb
  import dac_spi_arb_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  input  logic              dac_spi_ext_MISO,
  output logic              dac_spi_ext_MOSI,
  output logic              dac_spi_ext_SCLK,
  output logic              dac_spi_ext_SS_n
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);
  // GAP plus the following IDLE cycle keeps SS_n high for CLK_DIV cycles
  // between transfers. GAP needs at least one cycle to carry the ack.
  localparam int GAP_LEN = (CLK_DIV > 1) ? CLK_DIV - 1 : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(GAP_LEN - 1);
  localparam logic [BIT_W-1:0] BIT_DONE = BIT_W'(DATA_W);

  state_t              state_reg, state_next;
  logic [DIV_W-1:0]    div_reg, div_next, div_inc;
  logic [BIT_W-1:0]    bit_reg, bit_next;
  logic [DATA_W-1:0]   tx_reg, tx_next;
  logic [DATA_W-1:0]   rx_reg, rx_next;
  logic                grant_reg, grant_next;
  logic                last_grant_reg, last_grant_next;
  logic                ss_n_reg, ss_n_next;
  logic                sclk_reg, sclk_next;
  logic                mosi_reg, mosi_next;
  logic                busy_reg, busy_next;
  logic                ack0_reg, ack0_next;
  logic                ack1_reg, ack1_next;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;
  logic [1:0]          grant_vec;
  logic [DATA_W-1:0]   wdata_sel;

  spi_rr_arb2 u_arb (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_reg),
    .grant      (grant_vec)
  );

  assign wdata_sel = grant_vec[PORT_HW] ? wdata1 : wdata0;
  assign div_inc   = div_reg + DIV_W'(1);

  // Next-state, counters, shift registers and registered output values
  always_comb begin
    state_next      = state_reg;
    div_next        = div_reg;
    bit_next        = bit_reg;
    tx_next         = tx_reg;
    rx_next         = rx_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    ss_n_next       = ss_n_reg;
    sclk_next       = sclk_reg;
    mosi_next       = mosi_reg;
    busy_next       = busy_reg;
    ack0_next       = 1'b0;
    ack1_next       = 1'b0;
    rdata_next      = rdata_reg;

    case (state_reg)
      IDLE: begin
        if (|grant_vec) begin
          state_next      = SETUP;
          div_next        = '0;
          bit_next        = '0;
          grant_next      = grant_vec[PORT_HW];
          last_grant_next = grant_vec[PORT_HW];
          tx_next         = wdata_sel;
          ss_n_next       = 1'b0;
          mosi_next       = wdata_sel[DATA_W-1];
          busy_next       = 1'b1;
        end
      end
      SETUP: begin
        if (div_reg == DIV_LAST) begin
          state_next = SHIFT_HI;
          div_next   = '0;
          sclk_next  = 1'b1;
        end else begin
          div_next = div_inc;
        end
      end
      SHIFT_HI: begin
        // Slave data has been stable since the previous falling edge
        if (div_reg == '0) begin
          rx_next = {rx_reg[DATA_W-2:0], dac_spi_ext_MISO};
        end
        if (div_reg == DIV_LAST) begin
          state_next = SHIFT_LO;
          div_next   = '0;
          sclk_next  = 1'b0;
          bit_next   = bit_reg + BIT_W'(1);
          tx_next    = {tx_reg[DATA_W-2:0], 1'b0};
          mosi_next  = tx_reg[DATA_W-2];
        end else begin
          div_next = div_inc;
        end
      end
      SHIFT_LO: begin
        if (div_reg == DIV_LAST) begin
          div_next = '0;
          if (bit_reg == BIT_DONE) begin
            // The final low phase doubles as the SS hold time
            state_next = GAP;
            ss_n_next  = 1'b1;
            mosi_next  = 1'b0;
            ack0_next  = (grant_reg == 1'(PORT_CPU));
            ack1_next  = (grant_reg == 1'(PORT_HW));
            rdata_next = rx_reg;
          end else begin
            state_next = SHIFT_HI;
            sclk_next  = 1'b1;
          end
        end else begin
          div_next = div_inc;
        end
      end
      GAP: begin
        if (div_reg == GAP_LAST) begin
          state_next = IDLE;
          div_next   = '0;
          busy_next  = 1'b0;
        end else begin
          div_next = div_inc;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_reg      <= IDLE;
      div_reg        <= '0;
      bit_reg        <= '0;
      tx_reg         <= '0;
      rx_reg         <= '0;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      ss_n_reg       <= 1'b1;
      sclk_reg       <= 1'b0;
      mosi_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      ack0_reg       <= 1'b0;
      ack1_reg       <= 1'b0;
      rdata_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      div_reg        <= div_next;
      bit_reg        <= bit_next;
      tx_reg         <= tx_next;
      rx_reg         <= rx_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      ss_n_reg       <= ss_n_next;
      sclk_reg       <= sclk_next;
      mosi_reg       <= mosi_next;
      busy_reg       <= busy_next;
      ack0_reg       <= ack0_next;
      ack1_reg       <= ack1_next;
      rdata_reg      <= rdata_next;
    end
  end

  assign ack0             = ack0_reg;
  assign ack1             = ack1_reg;
  assign rdata            = rdata_reg;
  assign busy             = busy_reg;
  assign dac_spi_ext_MOSI = mosi_reg;
  assign dac_spi_ext_SCLK = sclk_reg;
  assign dac_spi_ext_SS_n = ss_n_reg;

endmodule

// File: tb/tb_dac_spi_arb.sv
// Bench for dac_spi_arb: instance 0 uses the defaults (16 bits, divider 4) and
// instance 1 uses 8 bits with divider 1. A transaction-level model predicts
// every output on every cycle from the grant time. Directed checks pin
// literal cycle numbers and data.
module tb_dac_spi_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst;
  logic [1:0]  req0, req1, ack0, ack1, busy, mosi, sclk, ss_n, miso;
  logic [1:0]  miso_loop, pat_bit;
  logic [15:0] wdata0_d0, wdata1_d0, rdata_d0;
  logic [7:0]  wdata0_d1, wdata1_d1, rdata_d1;
  logic [15:0] pat [2];

  int vectors = 0;
  int miscompares = 0;

  assign miso = (miso_loop & mosi) | (~miso_loop & pat_bit);

  dac_spi_arb u_dut0 (
    .clk_clk (clk), .reset_reset (rst),
    .req0 (req0[0]), .req1 (req1[0]), .wdata0 (wdata0_d0), .wdata1 (wdata1_d0),
    .ack0 (ack0[0]), .ack1 (ack1[0]), .rdata (rdata_d0), .busy (busy[0]),
    .dac_spi_ext_MISO (miso[0]), .dac_spi_ext_MOSI (mosi[0]),
    .dac_spi_ext_SCLK (sclk[0]), .dac_spi_ext_SS_n (ss_n[0])
  );

  dac_spi_arb #(.DATA_W(8), .CLK_DIV(1)) u_dut1 (
    .clk_clk (clk), .reset_reset (rst),
    .req0 (req0[1]), .req1 (req1[1]), .wdata0 (wdata0_d1), .wdata1 (wdata1_d1),
    .ack0 (ack0[1]), .ack1 (ack1[1]), .rdata (rdata_d1), .busy (busy[1]),
    .dac_spi_ext_MISO (miso[1]), .dac_spi_ext_MOSI (mosi[1]),
    .dac_spi_ext_SCLK (sclk[1]), .dac_spi_ext_SS_n (ss_n[1])
  );

  // Model state per instance
  bit          m_act  [2] = '{1'b0, 1'b0};
  bit          m_last [2] = '{1'b1, 1'b1};
  bit          m_win  [2] = '{1'b0, 1'b0};
  int          m_g    [2] = '{0, 0};
  logic [15:0] m_w    [2] = '{16'h0, 16'h0};
  logic [15:0] m_rx   [2] = '{16'h0, 16'h0};
  logic [15:0] m_rdata[2] = '{16'h0, 16'h0};

  // Observations taken from the pins
  bit          prev_ss   [2] = '{1'b1, 1'b1};
  bit          prev_sclk [2] = '{1'b0, 1'b0};
  int          ss_low    [2] = '{0, 0};
  int          rises     [2] = '{0, 0};
  int          ss_falls  [2] = '{0, 0};
  int          ack0_cnt  [2] = '{0, 0};
  int          ack1_cnt  [2] = '{0, 0};
  logic [15:0] cap       [2] = '{16'h0, 16'h0};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model, then model update from inputs
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int dw, cd, ssl, tid, t, j;
      bit in_win;
      logic [15:0] act_rd;
      logic [21:0] exp_v, act_v, mask_v;
      dw  = (i == 0) ? 16 : 8;
      cd  = (i == 0) ? 4 : 1;
      ssl = cd * (2 * dw + 1);
      tid = ssl + 1 + ((cd > 1) ? cd - 1 : 1);
      t   = cyc - m_g[i];
      if (m_act[i] && t >= tid) m_act[i] = 1'b0;
      in_win = m_act[i] && (t >= 1) && (t <= ssl);
      j = in_win ? (t - 1) / (2 * cd) : dw;
      if (m_act[i] && t == ssl + 1) m_rdata[i] = m_rx[i];
      pat_bit[i] = (in_win && j < dw) ? pat[i][dw-1-j] : 1'b0;

      exp_v = {!in_win,
               in_win && (((t - 1) / cd) % 2 == 1),
               (j < dw) ? m_w[i][dw-1-j] : 1'b0,
               m_act[i] && (t >= 1) && (t < tid),
               m_act[i] && (t == ssl + 1) && (m_win[i] == 1'b0),
               m_act[i] && (t == ssl + 1) && (m_win[i] == 1'b1),
               m_rdata[i]};
      mask_v = 22'h3FFFFF;
      if (in_win && j >= dw) mask_v[19] = 1'b0;
      act_rd = (i == 0) ? rdata_d0 : {8'h00, rdata_d1};
      act_v  = {ss_n[i], sclk[i], mosi[i], busy[i], ack0[i], ack1[i], act_rd};
      vectors++;
      if ((act_v & mask_v) !== (exp_v & mask_v)) begin
        miscompares++;
        $display("FAIL model_cycle inst %0d cycle %0d: {ss_n,sclk,mosi,busy,ack0,ack1,rdata} got %h, required %h (care %h)",
                 i, cyc, act_v, exp_v, mask_v);
      end

      // Pin observations for the directed checks
      if (prev_ss[i] && !ss_n[i]) begin
        ss_falls[i]++;
        ss_low[i] = 0;
        rises[i]  = 0;
        cap[i]    = 16'h0;
      end
      if (!ss_n[i]) ss_low[i]++;
      if (!prev_sclk[i] && sclk[i]) begin
        rises[i]++;
        cap[i] = {cap[i][14:0], mosi[i]};
      end
      prev_ss[i]   = ss_n[i];
      prev_sclk[i] = sclk[i];
      if (ack0[i] || ack1[i]) begin
        if (ack0[i]) ack0_cnt[i]++;
        if (ack1[i]) ack1_cnt[i]++;
        $display("xfer inst %0d port %0d rdata %h cycle %0d", i, ack1[i] ? 1 : 0, act_rd, cyc);
      end

      // Model update: reset or a grant from an idle cycle
      if (rst) begin
        m_act[i]   = 1'b0;
        m_last[i]  = 1'b1;
        m_rdata[i] = 16'h0;
      end else if (!m_act[i] && (req0[i] || req1[i])) begin
        m_win[i]  = (req0[i] && req1[i]) ? ~m_last[i] : ~req0[i];
        m_last[i] = m_win[i];
        m_g[i]    = cyc;
        m_act[i]  = 1'b1;
        if (i == 0) m_w[i] = m_win[i] ? wdata1_d0 : wdata0_d0;
        else        m_w[i] = {8'h00, m_win[i] ? wdata1_d1 : wdata0_d1};
        m_rx[i] = miso_loop[i] ? m_w[i] : (pat[i] & ((i == 0) ? 16'hFFFF : 16'h00FF));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int i, input int limit, output int port);
    port = -1;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (ack0[i]) begin port = 0; break; end
      if (ack1[i]) begin port = 1; break; end
    end
    if (port < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL ack_timeout inst %0d: got no ack in %0d cycles, required one", i, limit);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time 200000, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, p, snap;
    int exp_seq [6] = '{0, 1, 0, 1, 0, 1};
    rst = 1'b1;
    req0 = 2'b00; req1 = 2'b00;
    wdata0_d0 = 16'h0; wdata1_d0 = 16'h0; wdata0_d1 = 8'h0; wdata1_d1 = 8'h0;
    miso_loop = 2'b11;
    pat[0] = 16'h0; pat[1] = 16'h0;

    // Reset state
    @(negedge clk);
    check("reset_pins0", {ss_n[0], sclk[0], mosi[0], busy[0], ack0[0], ack1[0]}, 6'b100000);
    check("reset_rdata0", rdata_d0, 16'h0);
    check("reset_pins1", {ss_n[1], sclk[1], mosi[1], busy[1], ack0[1], ack1[1]}, 6'b100000);
    tick(1);
    rst = 1'b0;
    tick(2);

    // Single request with loopback
    req0[0] = 1'b1; wdata0_d0 = 16'hA55A; c0 = cyc;
    wait_ack(0, 300, p);
    check("t1_ack_cycle", cyc - c0, 133);
    check("t1_port", p, 0);
    check("t1_rdata", rdata_d0, 16'hA55A);
    check("t1_mosi_bits", cap[0], 16'b1010010101011010);
    check("t1_no_ack1", ack1_cnt[0], 0);
    tick(1);
    req0[0] = 1'b0;

    // Tie right after reset: port 0 first, port 1 next
    tick(5); rst = 1'b1; tick(1); rst = 1'b0; tick(2);
    req0[0] = 1'b1; req1[0] = 1'b1; wdata0_d0 = 16'h1234; wdata1_d0 = 16'hBEEF; c0 = cyc;
    wait_ack(0, 300, p);
    check("t2_first_port", p, 0);
    check("t2_first_ack_cycle", cyc - c0, 133);
    check("t2_first_rdata", rdata_d0, 16'h1234);
    tick(1);
    req0[0] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!ss_n[0]) break;
    end
    check("t2_second_ss_fall", cyc - c0, 137);
    wait_ack(0, 300, p);
    check("t2_second_port", p, 1);
    check("t2_second_ack_cycle", cyc - c0, 269);
    check("t2_second_rdata", rdata_d0, 16'hBEEF);
    tick(1);
    req1[0] = 1'b0;

    // Fairness: both ports re-request right after every ack
    tick(3);
    req0[0] = 1'b1; req1[0] = 1'b1; wdata0_d0 = 16'h0F01; wdata1_d0 = 16'hF010;
    for (int k = 0; k < 6; k++) begin
      wait_ack(0, 300, p);
      check($sformatf("t3_grant_%0d", k), p, exp_seq[k]);
      tick(1);
      if (k == 5) begin
        req0[0] = 1'b0; req1[0] = 1'b0;
      end else if (p == 0) req0[0] = 1'b0;
      else req1[0] = 1'b0;
      tick(1);
      if (k < 5) begin
        if (p == 0) begin req0[0] = 1'b1; wdata0_d0 = wdata0_d0 + 16'h0101; end
        else begin req1[0] = 1'b1; wdata1_d0 = wdata1_d0 + 16'h1010; end
      end
    end

    // Withdrawn request while busy; wdata change after grant
    tick(10);
    req0[0] = 1'b1; wdata0_d0 = 16'h3C3C; c0 = cyc;
    snap = ack1_cnt[0];
    tick(5);
    wdata0_d0 = 16'hFFFF;
    tick(15);
    req1[0] = 1'b1;
    tick(1);
    req1[0] = 1'b0;
    wait_ack(0, 300, p);
    check("t6_port", p, 0);
    check("t6_rdata", rdata_d0, 16'h3C3C);
    check("t6_mosi_bits", cap[0], 16'h3C3C);
    tick(1);
    req0[0] = 1'b0;
    tick(200);
    check("t6_no_port1_xfer", ack1_cnt[0], snap);

    // Reset in the middle of a transfer
    tick(5);
    req0[0] = 1'b1; wdata0_d0 = 16'h5A5A; c0 = cyc;
    tick(50);
    check("t5_mid_xfer_ss", ss_n[0], 1'b0);
    rst = 1'b1; req0[0] = 1'b0;
    snap = ack0_cnt[0];
    tick(1);
    check("t5_after_reset", {ss_n[0], sclk[0], busy[0]}, 3'b100);
    check("t5_rdata_cleared", rdata_d0, 16'h0);
    rst = 1'b0;
    tick(200);
    check("t5_no_ack", ack0_cnt[0], snap);
    req0[0] = 1'b1; wdata0_d0 = 16'h6699; c0 = cyc;
    wait_ack(0, 300, p);
    check("t5_recover_ack_cycle", cyc - c0, 133);
    check("t5_recover_rdata", rdata_d0, 16'h6699);
    tick(1);
    req0[0] = 1'b0;

    // 8-bit, divider 1, MISO driven with 0xC3
    tick(5);
    miso_loop[1] = 1'b0; pat[1] = 16'h00C3;
    req0[1] = 1'b1; wdata0_d1 = 8'h81; c0 = cyc;
    wait_ack(1, 100, p);
    check("t4_ack_cycle", cyc - c0, 18);
    check("t4_rdata", rdata_d1, 8'hC3);
    check("t4_sclk_rises", rises[1], 8);
    check("t4_ss_low_cycles", ss_low[1], 17);
    check("t4_mosi_bits", cap[1][7:0], 8'h81);
    tick(1);
    req0[1] = 1'b0;

    tick(10);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
